// File: rtl/keypad_calc_pkg.sv
// Shared types and constants for the keypad calculator: FSM states, key codes and
// the operator encoding (chosen so an operator key's low two bits are its opcode).
package keypad_calc_pkg;

  typedef enum logic [2:0] {
    StEnterA,
    StOp,
    StEnterB,
    StDivide,
    StResult,
    StError
  } state_e;

  // Operator key codes are 10..13, so op = key_code[1:0]
  typedef enum logic [1:0] {
    OpMul = 2'd0,
    OpDiv = 2'd1,
    OpAdd = 2'd2,
    OpSub = 2'd3
  } op_e;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/calc_div.sv
// Restoring unsigned divider. The first quotient bit is resolved on the start edge,
// so the quotient is ready, with done high, exactly WIDTH cycles after start.
module calc_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quot_q, dvs_q;
  logic [WIDTH-1:0] src_rem, src_quot, dvs, rem_n, quot_n;
  logic [WIDTH:0]   shifted;
  logic [CntW-1:0]  cnt_q, cnt_n;
  logic             run_q, done_q, step;

  always_comb begin
    step     = start_i || run_q;
    src_rem  = start_i ? '0 : rem_q;
    src_quot = start_i ? dividend_i : quot_q;
    dvs      = start_i ? divisor_i : dvs_q;
    cnt_n    = start_i ? CntW'(1) : CntW'(cnt_q + 1'b1);
    shifted  = {src_rem, src_quot[WIDTH-1]};
    if (shifted >= {1'b0, dvs}) begin
      rem_n  = WIDTH'(shifted - {1'b0, dvs});
      quot_n = (src_quot << 1) | WIDTH'(1);
    end else begin
      rem_n  = shifted[WIDTH-1:0];
      quot_n = src_quot << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= step && (cnt_n == CntW'(WIDTH));
      if (start_i) dvs_q <= divisor_i;
      if (step) begin
        rem_q  <= rem_n;
        quot_q <= quot_n;
        cnt_q  <= cnt_n;
        run_q  <= (cnt_n != CntW'(WIDTH));
      end
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quot_q;

endmodule

// File: rtl/keypad_calc.sv
// Keypad calculator: debounces a one-hot row/column keypad into key codes and runs a
// four-function unsigned calculator FSM with an iterative divider.
module keypad_calc
  import keypad_calc_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_DIGITS      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       IO_P4_ROW,
  input  logic [3:0]       IO_P4_COL,
  output logic [WIDTH-1:0] answer,
  output logic             error,
  output logic             busy,
  output logic             key_valid,
  output logic [3:0]       key_code
);

  localparam int unsigned DigW    = $clog2(MAX_DIGITS + 1);
  localparam logic [7:0]  DbLimit = 8'(DEBOUNCE_CYCLES);

  // Debounce
  logic       raw_valid, same, accept, armed_d, armed_q, last_valid_q, key_valid_q;
  logic [3:0] raw_code, last_code_q, key_code_q;
  logic [7:0] stable_d, stable_q;

  always_comb begin
    raw_valid = $onehot(IO_P4_ROW) && $onehot(IO_P4_COL);
    raw_code  = {onehot_idx(IO_P4_ROW), onehot_idx(IO_P4_COL)};
    same      = raw_valid && last_valid_q && (raw_code == last_code_q);
    if (!raw_valid)               stable_d = 8'd0;
    else if (!same)               stable_d = 8'd1;
    else if (stable_q != DbLimit) stable_d = stable_q + 8'd1;
    else                          stable_d = stable_q;
    // A change of code (including release) re-arms acceptance
    accept  = raw_valid && (armed_q || !same) && (stable_d == DbLimit);
    armed_d = accept ? 1'b0 : (same ? armed_q : 1'b1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_code_q  <= '0;
      last_valid_q <= 1'b0;
      stable_q     <= '0;
      armed_q      <= 1'b1;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
    end else begin
      last_code_q  <= raw_code;
      last_valid_q <= raw_valid;
      stable_q     <= stable_d;
      armed_q      <= armed_d;
      key_valid_q  <= accept;
      if (accept) key_code_q <= raw_code;
    end
  end

  // Calculator FSM
  state_e           state_q, state_d;
  op_e              op_q, op_d, key_op;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, answer_q, answer_d, alu_res, digit, div_quot;
  logic [DigW-1:0]  a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic             div_to_op_q, div_to_op_d, div_start, div_done, is_digit, is_op;

  always_comb begin
    is_digit = key_code_q < 4'd10;
    is_op    = (key_code_q >= KEY_ADD) && (key_code_q <= KEY_DIV);
    key_op   = op_e'(key_code_q[1:0]);
    digit    = WIDTH'(key_code_q);
    case (op_q)
      OpAdd:   alu_res = a_q + b_q;
      OpSub:   alu_res = a_q - b_q;
      OpMul:   alu_res = a_q * b_q;
      default: alu_res = a_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    a_cnt_d     = a_cnt_q;
    b_cnt_d     = b_cnt_q;
    answer_d    = answer_q;
    div_to_op_d = div_to_op_q;
    div_start   = 1'b0;
    if (state_q == StDivide) begin
      if (div_done) begin
        a_d      = div_quot;
        answer_d = div_quot;
        state_d  = div_to_op_q ? StOp : StResult;
      end
    end else if (key_valid_q && state_q != StError) begin
      if (is_digit) begin
        case (state_q)
          StEnterA: if (a_cnt_q < DigW'(MAX_DIGITS)) begin
            a_d      = a_q * WIDTH'(10) + digit;
            a_cnt_d  = a_cnt_q + 1'b1;
            answer_d = a_d;
          end
          StEnterB: if (b_cnt_q < DigW'(MAX_DIGITS)) begin
            b_d      = b_q * WIDTH'(10) + digit;
            b_cnt_d  = b_cnt_q + 1'b1;
            answer_d = b_d;
          end
          StOp: begin
            b_d      = digit;
            b_cnt_d  = DigW'(1);
            answer_d = digit;
            state_d  = StEnterB;
          end
          StResult: begin
            a_d      = digit;
            a_cnt_d  = DigW'(1);
            answer_d = digit;
            state_d  = StEnterA;
          end
          default: ;
        endcase
      end else if (is_op && state_q != StEnterB) begin
        op_d    = key_op;
        state_d = StOp;
      end else if ((is_op || key_code_q == KEY_EQ) && state_q == StEnterB) begin
        if (op_q == OpDiv) begin
          if (b_q == '0) begin
            state_d  = StError;
            answer_d = '1;
          end else begin
            div_start   = 1'b1;
            div_to_op_d = is_op;
            state_d     = StDivide;
          end
        end else begin
          a_d      = alu_res;
          answer_d = alu_res;
          state_d  = is_op ? StOp : StResult;
        end
        if (is_op) op_d = key_op;
      end
    end
    // Clear wins over everything, including a division in flight
    if (key_valid_q && key_code_q == KEY_CLR) begin
      state_d     = StEnterA;
      op_d        = OpMul;
      a_d         = '0;
      b_d         = '0;
      a_cnt_d     = '0;
      b_cnt_d     = '0;
      answer_d    = '0;
      div_to_op_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StEnterA;
      op_q        <= OpMul;
      a_q         <= '0;
      b_q         <= '0;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
      answer_q    <= '0;
      div_to_op_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      a_cnt_q     <= a_cnt_d;
      b_cnt_q     <= b_cnt_d;
      answer_q    <= answer_d;
      div_to_op_q <= div_to_op_d;
    end
  end

  calc_div #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .dividend_i (a_q),
    .divisor_i  (b_q),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  assign answer    = answer_q;
  assign error     = (state_q == StError);
  assign busy      = (state_q == StDivide);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_calc.sv
// Bench for keypad_calc: directed calculator sessions followed by random key
// sequences, each checked against a behavioural calculator model.
module tb_keypad_calc;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row, col;
  logic [31:0] answer;
  logic        error, busy, key_valid;
  logic [3:0]  key_code;

  always #5 clk = ~clk;

  keypad_calc #(
    .WIDTH(32),
    .DEBOUNCE_CYCLES(4),
    .MAX_DIGITS(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .IO_P4_ROW (row),
    .IO_P4_COL (col),
    .answer    (answer),
    .error     (error),
    .busy      (busy),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  int total = 0, passed = 0, fails = 0;
  int pulses = 0, busy_cnt = 0;

  // Calculator model: mode 0 entering A, 1 operator given, 2 entering B,
  // 3 showing result, 4 error
  int          m_mode, m_op, m_ad, m_bd;
  logic [31:0] m_a, m_b, m_ans;
  bit          m_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
    if (key_valid) pulses++;
  endtask

  function automatic logic [31:0] arith(input logic [31:0] a, input logic [31:0] b,
                                        input int op);
    longint unsigned x, y, r;
    x = a;
    y = b;
    case (op)
      10:      r = x + y;
      11:      r = x - y;
      12:      r = x * y;
      default: r = x / y;
    endcase
    return r[31:0];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_op = 12; m_ad = 0; m_bd = 0;
    m_a = 0; m_b = 0; m_ans = 0; m_busy = 0;
  endtask

  task automatic model_apply(input int k);
    if (k == 15) begin
      model_reset();
    end else if (m_busy || m_mode == 4) begin
      // swallowed
    end else if (k <= 9) begin
      if (m_mode == 0 && m_ad < 8) begin
        m_a = m_a * 10 + k; m_ad++; m_ans = m_a;
      end else if (m_mode == 2 && m_bd < 8) begin
        m_b = m_b * 10 + k; m_bd++; m_ans = m_b;
      end else if (m_mode == 1) begin
        m_b = k; m_bd = 1; m_ans = m_b; m_mode = 2;
      end else if (m_mode == 3) begin
        m_a = k; m_ad = 1; m_ans = m_a; m_mode = 0;
      end
    end else if (k == 14 && m_mode != 2) begin
      // '=' outside operand B does nothing
    end else if (m_mode != 2) begin
      m_op = k; m_mode = 1;
    end else if (m_op == 13 && m_b == 0) begin
      m_mode = 4; m_ans = 32'hFFFF_FFFF;
    end else begin
      if (m_op == 13) m_busy = 1;
      m_a = arith(m_a, m_b, m_op);
      m_ans = m_a;
      if (k == 14) m_mode = 3;
      else begin m_op = k; m_mode = 1; end
    end
  endtask

  task automatic press(input int k, input int hold, input int gap);
    if (!m_busy) busy_cnt = 0;
    pulses = 0;
    row = 4'(1 << (k / 4));
    col = 4'(1 << (k % 4));
    repeat (hold) tick();
    row = 4'd0;
    col = 4'd0;
    repeat (gap) tick();
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_answer"}, answer, m_ans);
    chk({tag, "_error"}, 32'(error), 32'(m_mode == 4));
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic key(input int k, input int gap);
    press(k, 10, gap);
    model_apply(k);
    chk("key_valid_pulses", 32'(pulses), 1);
    chk("key_code", 32'(key_code), 32'(k));
    if (m_busy) chk("busy_in_divide", 32'(busy), 1);
    else check_outputs("after_key");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("divide_busy_cycles", 32'(busy_cnt), 32);
    m_busy = 0;
    check_outputs("after_divide");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seq_a[] = '{0, 5, 2, 5, 2};
    int exp_a[] = '{0, 5, 52, 525, 5252};
    reset = 1'b0;
    row = 4'd0;
    col = 4'd0;
    model_reset();
    repeat (3) tick();
    chk("reset_answer", answer, 0);
    chk("reset_error", 32'(error), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_key_valid", 32'(key_valid), 0);
    chk("reset_key_code", 32'(key_code), 0);
    reset = 1'b1;
    tick();

    // Digits rolled without release
    for (int i = 0; i < 5; i++) begin
      key(seq_a[i], (i == 4) ? 2 : 0);
      chk("rolled_digit_answer", answer, 32'(exp_a[i]));
    end
    key(15, 2);

    // 12+3= then *2=
    key(1, 2); key(2, 2); key(10, 2); key(3, 2); key(14, 2);
    chk("sum_15", answer, 32'd15);
    key(12, 2); key(2, 2); key(14, 2);
    chk("product_30", answer, 32'd30);

    // 3-5= wraps, then 1..9 truncates at eight digits
    key(15, 2); key(3, 2); key(11, 2); key(5, 2); key(14, 2);
    chk("wrap_sub", answer, 32'hFFFF_FFFE);
    for (int d = 1; d <= 9; d++) key(d, 2);
    chk("eight_digits", answer, 32'd12345678);

    // 100/7= with a digit pressed while dividing
    key(15, 2); key(1, 2); key(0, 2); key(0, 2); key(13, 2); key(7, 2); key(14, 2);
    key(4, 2);
    wait_idle();
    chk("quotient_14", answer, 32'd14);

    // Divide by zero
    key(15, 2); key(8, 2); key(13, 2); key(0, 2); key(14, 2);
    chk("div0_error", 32'(error), 1);
    chk("div0_answer", answer, 32'hFFFF_FFFF);
    key(5, 2);
    key(15, 2);
    chk("clear_error", 32'(error), 0);

    // Reset during a division
    key(1, 2); key(0, 2); key(0, 2); key(13, 2); key(7, 2); key(14, 2);
    reset = 1'b0;
    tick();
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_answer", answer, 0);
    chk("midreset_key_valid", 32'(key_valid), 0);
    chk("midreset_key_code", 32'(key_code), 0);
    reset = 1'b1;
    model_reset();
    repeat (40) tick();
    chk("postreset_busy", 32'(busy), 0);
    press(7, 3, 2);
    chk("short_press_pulses", 32'(pulses), 0);
    chk("short_press_answer", answer, 0);
    key(7, 2);

    // Random key sequences
    for (int i = 0; i < 80; i++) begin
      int k;
      k = int'($urandom_range(0, 15));
      if (k == 15 && $urandom_range(0, 3) != 0) k = int'($urandom_range(0, 9));
      key(k, 2);
      if (m_busy) wait_idle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/keypad_calc.md
KEYPAD_CALC -- requirements
Module: keypad_calc

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles before a key is accepted (range 1..255).
REQ-003 SHALL have parameter MAX_DIGITS, default 8: maximum decimal digits per operand.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port IO_P4_ROW  input  4  keypad row, one-hot.
REQ-007 SHALL have port IO_P4_COL  input  4  keypad column, one-hot.
REQ-008 SHALL have port answer  output  WIDTH  operand being entered, or the last result.
REQ-009 SHALL have port error  output  1  high while in the ERROR state.
REQ-010 SHALL have port busy  output  1  high while a division is in progress.
REQ-011 SHALL have port key_valid  output  1  one-cycle pulse per accepted key.
REQ-012 SHALL have port key_code  output  4  code of the last accepted key.

Function
REQ-013 SHALL decode key code = 4*r + c when ROW has exactly one bit set (bit r) and COL has exactly one bit set (bit c); any other input pattern is "no key".
REQ-014 SHALL map key codes as follows: 0-9 digits; 10 '+'; 11 '-'; 12 '*'; 13 '/'; 14 '='; 15 'C'.
REQ-015 SHALL accept a key when the same valid code has been stable for DEBOUNCE_CYCLES cycles; key_valid pulses in that cycle.
REQ-016 SHALL accept a held code only once; acceptance re-arms when the code changes, either through "no key" or directly to a different code.
REQ-017 SHALL ignore and discard keys accepted while busy=1, except 'C'.
REQ-018 SHALL implement these FSM states: ENTER_A, OP, ENTER_B, DIVIDE, RESULT, ERROR.
REQ-019 SHALL handle a digit in ENTER_A or ENTER_B by setting operand = operand*10 + digit (mod 2^WIDTH); digits beyond MAX_DIGITS are ignored.
REQ-020 SHALL handle a digit in RESULT by clearing A, loading the digit and going to ENTER_A.
REQ-021 SHALL handle an operator in ENTER_A or RESULT by latching the operator and going to OP.
REQ-022 SHALL handle an operator in OP by replacing the latched operator.
REQ-023 SHALL handle a digit in OP by starting B with that digit and going to ENTER_B.
REQ-024 SHALL handle an operator in ENTER_B by computing A op B, storing the result into A, latching the new operator and going to OP.
REQ-025 SHALL handle '=' in ENTER_B by computing and going to RESULT; '=' in other states is a no-op.
REQ-026 SHALL compute unsigned arithmetic modulo 2^WIDTH: '-' wraps; '*' keeps the low WIDTH bits; '/' gives the quotient.
REQ-027 SHALL complete '+', '-' and '*' in one cycle; answer updates on the cycle after key_valid.
REQ-028 SHALL perform '/' iteratively in DIVIDE: busy=1 for exactly WIDTH cycles starting the cycle after key_valid, with the result on answer the cycle busy falls.
REQ-029 SHALL treat divide by zero as an error: go to ERROR with no DIVIDE cycles; answer = all ones; error = 1.
REQ-030 SHALL ignore all keys except 'C' in ERROR.
REQ-031 SHALL handle 'C' in any state, including DIVIDE, by clearing A, B and the operator, setting answer = 0, error = 0, busy = 0 and going to ENTER_A the next cycle.

Reset
REQ-032 SHALL, on reset = 0 at a clock edge, set answer = 0, error = 0, busy = 0, key_valid = 0, key_code = 0, state = ENTER_A and clear all operands.
REQ-033 SHALL, on reset = 0 at a clock edge, clear the debounce counter and leave acceptance armed.
REQ-034 SHALL give reset priority over every event, including a division in progress, which is abandoned.

Structure
REQ-035 SHALL place the FSM state enum, key-code constants (KEY_ADD=10 ... KEY_CLR=15) and operator encoding in package keypad_calc_pkg.
REQ-036 SHALL implement the restoring divider as sub-module calc_div with start/done handshake, WIDTH parameter and the same clk/reset.

Verification (WIDTH=32, DEBOUNCE_CYCLES=4, each key held 10 cycles)
REQ-037 SHALL cover: keys 0,5,2,5,2 with no release between them -> answer 5, 52, 525, 5252, with one key_valid pulse per key.
REQ-038 SHALL cover: 1,2,+,3,= -> answer 15; then *,2,= -> answer 30.
REQ-039 SHALL cover: 3,-,5,= -> answer 0xFFFFFFFE; digits 1..9 -> answer 12345678.
REQ-040 SHALL cover: 1,0,0,/,7,= -> busy high for 32 cycles, then answer 14; a '4' pressed during busy is ignored.
REQ-041 SHALL cover: 8,/,0,= -> error=1, answer 0xFFFFFFFF, a digit is ignored; then C -> error=0, answer 0.
REQ-042 SHALL cover: reset=0 asserted mid-division -> next cycle busy=0, answer 0, state ENTER_A; a key held fewer than 4 cycles produces no key_valid.
